// File: rtl/song_memory_bank.sv
// Multi-slot song store: appends notes per slot and streams a latched slot out one note per read.
// Define SONG_LOOP_EN to make playback wrap to the first note instead of stopping after the last.
module song_memory_bank #(
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 64,
  parameter int SLOTS       = 4,
  parameter int STATE_WIDTH = 2,
  localparam int ADDR_W     = $clog2(DEPTH),
  localparam int SLOT_W     = $clog2(SLOTS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [STATE_WIDTH-1:0] current_state,
  input  logic [SLOT_W-1:0]      slot_sel,
  input  logic                   write_en,
  input  logic [DATA_WIDTH-1:0]  data_in,
  input  logic                   clear_slot,
  input  logic                   read_en,
  input  logic                   read_rst,
  output logic [DATA_WIDTH-1:0]  data_out,
  output logic                   output_ready,
  output logic [ADDR_W:0]        duration,
  output logic                   play_done,
  output logic                   full,
  output logic [1:0]             dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, PLAY = 2'd1, DONE = 2'd2} state_e;

  logic [DATA_WIDTH-1:0] mem_q [SLOTS][DEPTH];
  logic [ADDR_W:0]       len_q [SLOTS];

  state_e                state_q, state_d;
  logic [ADDR_W:0]       rd_ptr_q, rd_ptr_d;
  logic [SLOT_W-1:0]     play_slot_q, play_slot_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  output_ready_q, output_ready_d;
  logic                  play_done_q, play_done_d;

  logic                  active;
  logic [ADDR_W:0]       sel_len, cur_len, ptr_inc;
  logic                  wr_fire;

  assign active  = (current_state != '1);
  assign sel_len = len_q[slot_sel];
  assign cur_len = len_q[play_slot_q];
  assign ptr_inc = rd_ptr_q + 1'b1;
  assign full    = (sel_len == (ADDR_W+1)'(DEPTH));
  assign wr_fire = write_en && !clear_slot && !full;

  // Storage carries no reset; the read below sees pre-write contents on a same-cycle write.
  always_ff @(posedge clk) begin
    if (wr_fire) mem_q[slot_sel][sel_len[ADDR_W-1:0]] <= data_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SLOTS; s++) len_q[s] <= '0;
    end else if (clear_slot) begin
      len_q[slot_sel] <= '0;
    end else if (wr_fire) begin
      len_q[slot_sel] <= sel_len + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      rd_ptr_q       <= '0;
      play_slot_q    <= '0;
      data_out_q     <= '0;
      output_ready_q <= 1'b0;
      play_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      rd_ptr_q       <= rd_ptr_d;
      play_slot_q    <= play_slot_d;
      data_out_q     <= data_out_d;
      output_ready_q <= output_ready_d;
      play_done_q    <= play_done_d;
    end
  end

  // Handshake: read_en in PLAY is accepted on that edge; its note appears with a one-cycle
  // output_ready strobe on the next cycle. There is no backpressure; unaccepted requests are dropped.
  always_comb begin
    state_d        = state_q;
    rd_ptr_d       = rd_ptr_q;
    play_slot_d    = (state_q == IDLE) ? slot_sel : play_slot_q;
    data_out_d     = data_out_q;
    output_ready_d = 1'b0;
    play_done_d    = 1'b0;
    if (!active) begin
      state_d    = IDLE;
      rd_ptr_d   = '0;
      data_out_d = '0;
    end else if (read_rst) begin
      state_d  = IDLE;
      rd_ptr_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          rd_ptr_d = '0;
          state_d  = PLAY;
        end
        PLAY: begin
          if (read_en) begin
            if (rd_ptr_q < cur_len) begin
              data_out_d     = mem_q[play_slot_q][rd_ptr_q[ADDR_W-1:0]];
              output_ready_d = 1'b1;
              rd_ptr_d       = ptr_inc;
              if (ptr_inc == cur_len) begin
                play_done_d = 1'b1;
`ifdef SONG_LOOP_EN
                rd_ptr_d = '0;
`else
                state_d = DONE;
`endif
              end
            end else begin
              // Empty slot (or one cleared under the pointer): nothing left to deliver.
              play_done_d = 1'b1;
              state_d     = DONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign data_out     = active ? data_out_q : '0;
  assign output_ready = output_ready_q && active && !read_rst;
  assign play_done    = play_done_q;
  assign duration     = cur_len;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_song_memory_bank.sv
// Directed bench for song_memory_bank: a note-level playback model checked every cycle plus literal note lists.
module tb_song_memory_bank;
  localparam int DW = 8, DEPTH = 64, SLOTS = 4, AW = 6, SW = 2;
`ifdef SONG_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    current_state = 2'b00;
  logic [SW-1:0] slot_sel = '0;
  logic          write_en = 1'b0, clear_slot = 1'b0, read_en = 1'b0, read_rst = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic [DW-1:0] data_out;
  logic          output_ready, play_done, full;
  logic [AW:0]   duration;
  logic [1:0]    dbg_state;

  song_memory_bank dut (
    .clk(clk), .rst_n(rst_n), .current_state(current_state), .slot_sel(slot_sel),
    .write_en(write_en), .data_in(data_in), .clear_slot(clear_slot), .read_en(read_en),
    .read_rst(read_rst), .data_out(data_out), .output_ready(output_ready),
    .duration(duration), .play_done(play_done), .full(full), .dbg_state(dbg_state)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Song-level model: per-slot note lists, a "where am I in the song" index and a finished flag.
  logic [DW-1:0] m_mem [SLOTS][DEPTH];
  int            m_len [SLOTS];
  bit            m_started, m_finished;
  int            m_idx, m_slot;
  logic          e_rdy, e_done;
  logic [DW-1:0] e_data;
  bit            t_act;
  int            t_len, t_slot;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SLOTS; s++) m_len[s] = 0;
      m_started = 0; m_finished = 0; m_idx = 0; m_slot = 0;
      e_rdy = 0; e_done = 0; e_data = '0;
    end else begin
      t_act  = (current_state != 2'b11);
      t_len  = m_len[m_slot];
      t_slot = (!m_started && !m_finished) ? int'(slot_sel) : m_slot;
      e_rdy  = 0;
      e_done = 0;
      if (!t_act) e_data = '0;
      if (!t_act || read_rst) begin
        m_started = 0; m_finished = 0; m_idx = 0;
      end else if (!m_started && !m_finished) begin
        m_started = 1;
      end else if (m_started && read_en) begin
        if (m_idx < t_len) begin
          e_data = m_mem[m_slot][m_idx];
          e_rdy  = 1;
          m_idx  = m_idx + 1;
          if (m_idx == t_len) begin
            e_done = 1;
            if (LOOP) m_idx = 0;
            else begin m_started = 0; m_finished = 1; end
          end
        end else begin
          e_done = 1; m_started = 0; m_finished = 1;
        end
      end
      m_slot = t_slot;
      if (clear_slot) m_len[slot_sel] = 0;
      else if (write_en && m_len[slot_sel] < DEPTH) begin
        m_mem[slot_sel][m_len[slot_sel]] = data_in;
        m_len[slot_sel] = m_len[slot_sel] + 1;
      end
    end
  end

  logic [DW-1:0] got_q [$];
  logic [DW-1:0] exp_q [$];
  int            done_cnt;
  bit            c_act, c_rdy;

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      c_act = (current_state != 2'b11);
      c_rdy = e_rdy && c_act && !read_rst;
      chk("output_ready", output_ready, c_rdy);
      if (c_rdy) chk("data_out", data_out, e_data);
      if (!c_act) chk("data_out_inactive", data_out, 0);
      chk("play_done", play_done, e_done);
      chk("duration", duration, m_len[m_slot]);
      chk("full", full, m_len[slot_sel] == DEPTH);
      if (output_ready) got_q.push_back(data_out);
      if (play_done) done_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wr(input int s, input logic [DW-1:0] d);
    slot_sel = SW'(s); data_in = d; write_en = 1'b1;
    tick();
    write_en = 1'b0;
  endtask

  task automatic restart(input int s);
    slot_sel = SW'(s); read_rst = 1'b1;
    tick();
    read_rst = 1'b0;
    tick();
  endtask

  task automatic reads(input int n);
    read_en = 1'b1;
    repeat (n) tick();
    read_en = 1'b0;
    tick();
  endtask

  task automatic clear_cap();
    got_q.delete(); done_cnt = 0;
  endtask

  task automatic chk_notes(input string nm, input int exp_done);
    chk({nm, "_count"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) chk({nm, "_note"}, got_q[i], exp_q[i]);
    chk({nm, "_done"}, done_cnt, exp_done);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data_out", data_out, 0);
    chk("rst_output_ready", output_ready, 0);
    chk("rst_play_done", play_done, 0);
    chk("rst_duration", duration, 0);
    chk("rst_state", dbg_state, 0);
    rst_n = 1'b1; chk_en = 1'b1;

    // Empty slot 0 in autoplay
    clear_cap(); tick(); tick();
    reads(2); tick();
    exp_q = {}; chk_notes("empty_slot", 1);
    chk("empty_duration", duration, 0);

    // Three notes on slot 2 in learning state
    wr(2, 8'h11); wr(2, 8'h22); wr(2, 8'h33);
    current_state = 2'b01;
    clear_cap(); restart(2); reads(3);
    exp_q = {8'h11, 8'h22, 8'h33}; chk_notes("three_notes", 1);
    chk("three_duration", duration, 3);

    // Leave the active states mid-song, then come back and start over
    current_state = 2'b00;
    clear_cap(); restart(2);
    read_en = 1'b1; tick(); tick();
    read_en = 1'b0; current_state = 2'b11;
    #1;
    chk("inactive_ready", output_ready, 0);
    chk("inactive_data", data_out, 0);
    tick(); current_state = 2'b00; tick();
    reads(1);
    exp_q = {8'h11, 8'h11}; chk_notes("resume", 0);

    // Fill slot 1 and try one more
    for (int i = 0; i < DEPTH; i++) wr(1, 8'(8'h40 + i));
    chk("full_after_fill", full, 1);
    wr(1, 8'hFF);
    chk("full_after_overflow", full, 1);
    clear_cap(); restart(1);
    chk("full_duration", duration, 64);
    reads(DEPTH);
    chk("full_count", got_q.size(), 64);
    if (got_q.size() == 64) begin
      chk("full_first", got_q[0], 8'h40);
      chk("full_word63", got_q[63], 8'h7F);
    end
    chk("full_done", done_cnt, 1);

    // Clear beats a same-cycle write
    for (int i = 0; i < 4; i++) wr(3, 8'(8'hA0 + i));
    restart(3);
    chk("slot3_duration", duration, 4);
    slot_sel = 2'd3; clear_slot = 1'b1; write_en = 1'b1; data_in = 8'hEE;
    tick();
    clear_slot = 1'b0; write_en = 1'b0;
    chk("clear_duration", duration, 0);
    chk("clear_full", full, 0);
    wr(3, 8'hB0);
    clear_cap(); restart(3); reads(1);
    exp_q = {8'hB0}; chk_notes("after_clear", 1);
    chk("after_clear_duration", duration, 1);

    // Same-cycle append and read on an empty playing slot: the read sees the old length
    clear_cap(); restart(0);
    slot_sel = 2'd0; write_en = 1'b1; data_in = 8'h5A; read_en = 1'b1;
    tick();
    write_en = 1'b0; read_en = 1'b0;
    tick();
    reads(2);
    exp_q = {}; chk_notes("same_cycle", 1);
    chk("same_cycle_duration", duration, 1);

    // Past the end of the song
    clear_cap(); restart(2);
    if (LOOP) begin
      reads(7);
      exp_q = {8'h11, 8'h22, 8'h33, 8'h11, 8'h22, 8'h33, 8'h11}; chk_notes("loop", 2);
    end else begin
      reads(5);
      exp_q = {8'h11, 8'h22, 8'h33}; chk_notes("stop", 1);
    end

    // Asynchronous reset while a note is on the output
    restart(2);
    read_en = 1'b1; tick(); read_en = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("async_ready", output_ready, 0);
    chk("async_data", data_out, 0);
    chk("async_duration", duration, 0);
    chk("async_state", dbg_state, 0);
    tick(); rst_n = 1'b1; tick(); tick();
    chk("post_reset_duration", duration, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/song_memory_bank.md
# song_memory_bank

Multi-slot song store for the organ's playback path: holds up to `SLOTS` independent note sequences, appends notes to a selected slot, and streams a latched slot out one note per read request. It sits between the song loader and the autoplay/learning/game engines, replacing the single-song memory unit. It adds:
- per-slot lengths
- slot clear
- full detection
- end-of-song signalling
- optional looping playback

## Interface
Parameters:
- `DATA_WIDTH`, 8, width of one stored note word.
- `DEPTH`, 64, notes per slot (power of two, ≥2); `ADDR_W = $clog2(DEPTH)`.
- `SLOTS`, 4, number of song slots (power of two, ≥2); `SLOT_W = $clog2(SLOTS)`.
- `STATE_WIDTH`, 2, width of the system state code.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `current_state` in `STATE_WIDTH`: 00 autoplay, 01 learning, 10 game, 11 other (inactive).
- `slot_sel` in `SLOT_W`: slot targeted by write/clear; also the slot captured for playback.
- `write_en` in 1: append `data_in` to `slot_sel`.
- `data_in` in `DATA_WIDTH`: note word to store.
- `clear_slot` in 1: set length of `slot_sel` to 0.
- `read_en` in 1: request the next note of the playing slot.
- `read_rst` in 1: restart playback; recapture `slot_sel`.
- `data_out` out `DATA_WIDTH`: note read; valid only while `output_ready`=1.
- `output_ready` out 1: one-cycle valid strobe for `data_out`.
- `duration` out `ADDR_W+1`: stored length of the playing slot.
- `play_done` out 1: one-cycle pulse when the last note of the slot has been delivered.
- `full` out 1: combinational; the length of `slot_sel` equals `DEPTH`.

## Operation
- Storage: `SLOTS`×`DEPTH` words. Per-slot length registers `len[s]`, range 0..`DEPTH`.
- Write path works in every state:
  - `write_en` with `len[slot_sel]<DEPTH`: stores at `len[slot_sel]`, then `len`+1.
  - `write_en` with `len[slot_sel]==DEPTH`: dropped; memory and `len` unchanged.
  - `clear_slot` sets `len[slot_sel]=0`. If `write_en` is high in the same cycle, the clear wins and the write is dropped.
- Playback FSM states are IDLE, PLAY and DONE. The playing slot `play_slot` and read pointer `rd_ptr` are registers.
- Active means `current_state` ∈ {00,01,10}.
- IDLE:
  - `rd_ptr=0`; `play_slot<=slot_sel` every cycle.
  - Moves to PLAY when active and `read_rst`=0.
- Any state:
  - Inactive state or `read_rst`=1 → IDLE next cycle, `rd_ptr=0`.
  - An in-flight `output_ready` is suppressed.
- PLAY, on `read_en`:
  - If `rd_ptr<len[play_slot]`: next cycle `data_out=mem[play_slot][rd_ptr]`, `output_ready`=1, then `rd_ptr`+1.
  - If that note was the last one (`rd_ptr==len-1`), `play_done` pulses in the same cycle as its `output_ready`, and the FSM goes to DONE.
  - If `len[play_slot]==0`: no `output_ready`; `play_done` pulses next cycle; FSM goes to DONE.
- DONE: `read_en` is ignored. The FSM leaves DONE only through `read_rst` or an inactive state.
- `read_en` while in IDLE or DONE: ignored.
- `duration = len[play_slot]`. It tracks live appends to the playing slot; appends made during PLAY extend playback.
- Write and read to the same slot in one cycle: the read uses the `len` value from before the write. The read word comes from the pre-write memory.
- `data_out` and `output_ready` are 0 whenever inactive.

## Timing
- Reset values:
  - `data_out=0`, `output_ready=0`, `play_done=0`
  - FSM=IDLE, `rd_ptr=0`, `play_slot=0`
  - all `len=0`, so `duration=0`
  - memory contents are undefined.
- Read latency: exactly 1 cycle from `read_en` to `output_ready`. Back-to-back `read_en` gives one note per cycle.
- `output_ready` and `play_done` are single-cycle pulses.
- Entry: the first `read_en` is honoured on the cycle after the FSM enters PLAY. `read_en` in the IDLE→PLAY transition cycle is ignored.
- `rst_n` low mid-playback clears all state immediately, without waiting for a clock edge.

## Configuration
- `SONG_LOOP_EN` defined:
  - In PLAY, after the last note is delivered, `rd_ptr` wraps to 0 and the FSM stays in PLAY.
  - `play_done` still pulses on each wrap.
  - DONE is entered only when `len==0`.
- Undefined: playback stops in DONE after the last note, as described above.

## Test plan
- Reset then state 00, `read_en` ×2 on empty slot 0 → no `output_ready`; one `play_done` pulse; `duration=0`.
- Write 0x11, 0x22, 0x33 to slot 2, select slot 2, `read_rst` pulse, state 01, `read_en` ×3 back-to-back → `data_out` 0x11, 0x22, 0x33 on consecutive cycles, each 1 cycle after its `read_en`; `play_done` with 0x33; `duration=3`.
- Fill slot 1 with 64 writes, then write 0xFF → `full`=1; `len` stays 64; word 63 unchanged.
- Mid-playback (after 2 of 3 notes), switch state to 11 → `output_ready`=0, `data_out`=0. Return to 00 and `read_en` → 0x11 again.
- Same cycle: `clear_slot` + `write_en` on slot 3 with 4 notes → `len[3]=0`, write dropped.
- With `SONG_LOOP_EN`: 3-note slot, `read_en` ×7 → 0x11, 0x22, 0x33, 0x11, 0x22, 0x33, 0x11; `play_done` pulses twice.
